// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer time-sharing one combinational ALU among NUM_REQ requesters
//   i_clock      rising-edge clock
//   i_reset_n    asynchronous active-low reset
//   i_req_valid  per-requester request; o_req_ready one-hot accept (IDLE only)
//   i_req_a/b    packed operands, requester i at [i*DATA_W +: DATA_W]
//   i_req_op     packed 5-bit op codes, requester i at [i*5 +: 5]
//   o_alu_a/b/op registered ALU inputs; i_alu_c combinational ALU result
//   o_rsp_*      result handshake (valid/ready, data, owner id)
//   o_busy       high while a transaction is in EXEC or RESP
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
    input  logic [NUM_REQ*5-1:0]      i_req_op,
    output logic [DATA_W-1:0]         o_alu_a,
    output logic [DATA_W-1:0]         o_alu_b,
    output logic [4:0]                o_alu_op,
    input  logic [DATA_W-1:0]         i_alu_c,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic [ID_W-1:0]           o_rsp_id,
    output logic                      o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
    state_t              r_state, w_next;
    logic [ID_W-1:0]     r_ptr, r_gnt, w_gnt, w_idx;
    logic                w_found;
    logic [DATA_W-1:0]   r_alu_a, r_alu_b, r_rsp_data;
    logic [4:0]          r_alu_op;
    logic [ID_W-1:0]     r_rsp_id;
    logic                r_rsp_valid;
    // Scan from the highest offset down so the requester closest to r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_found ? S_EXEC : S_IDLE;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  w_next = i_rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_alu_a  <= i_req_a[w_gnt*DATA_W +: DATA_W];
                r_alu_b  <= i_req_b[w_gnt*DATA_W +: DATA_W];
                r_alu_op <= i_req_op[w_gnt*5 +: 5];
                r_gnt    <= w_gnt;
            end
            if (r_state == S_EXEC) begin
                r_rsp_data  <= i_alu_c;
                r_rsp_id    <= r_gnt;
                r_rsp_valid <= 1'b1;
            end
            if (r_state == S_RESP && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_ptr       <= (r_gnt == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
            end
        end
    end
    // Gate with reset so no requester sees an accept while reset is held.
    assign o_req_ready = (i_reset_n && r_state == S_IDLE && w_found)
                         ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt) : '0;
    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_op    = r_alu_op;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_id    = r_rsp_id;
    assign o_busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with a transaction-level model for alu_share_arbiter
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   req_valid = 4'b0;
    logic [3:0]   req_ready;
    logic [31:0]  ta [4];
    logic [31:0]  tbv [4];
    logic [4:0]   top [4];
    logic [127:0] req_a, req_b;
    logic [19:0]  req_op;
    logic [31:0]  alu_a, alu_b, alu_c, rsp_data;
    logic [4:0]   alu_op;
    logic         rsp_valid, busy;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic         auto_drop = 1'b1;
    int           checks = 0;
    int           failures = 0;

    initial for (int i = 0; i < 4; i++) begin
        ta[i] = '0; tbv[i] = '0; top[i] = '0;
    end

    always_comb begin
        req_a = '0; req_b = '0; req_op = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = ta[i];
            req_b[i*32 +: 32] = tbv[i];
            req_op[i*5 +: 5]  = top[i];
        end
    end

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        case (op)
            5'd0:    return a | b;
            5'd1:    return a & b;
            5'd2:    return a + b;
            5'd3:    return 32'd0 - a;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_c = alu_fn(alu_a, alu_b, alu_op);

    alu_share_arbiter #(.NUM_REQ(4), .ID_W(2), .DATA_W(32)) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .i_alu_c(alu_c),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_id(rsp_id), .o_busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: phase 0 waiting for a grant, 1 operation issued, 2 result offered.
    int          m_st, m_ptr, m_g, m_id, m_pick;
    logic [31:0] m_a, m_b, m_d;
    logic [4:0]  m_op;

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_ptr = 0; m_g = 0; m_id = 0;
            m_a = 0; m_b = 0; m_d = 0; m_op = 0;
        end else if (m_st == 0) begin
            m_pick = pick(req_valid, m_ptr);
            if (m_pick >= 0) begin
                m_g = m_pick; m_a = ta[m_g]; m_b = tbv[m_g]; m_op = top[m_g]; m_st = 1;
            end
        end else if (m_st == 1) begin
            m_d = alu_fn(m_a, m_b, m_op); m_id = m_g; m_st = 2;
        end else if (rsp_ready) begin
            m_ptr = (m_g + 1) % 4; m_st = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int p;
            p = pick(req_valid, m_ptr);
            chk("m_req_ready", 32'(req_ready), (m_st == 0 && p >= 0) ? 32'(1) << p : 32'd0);
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_st == 2));
            chk("m_busy", 32'(busy), 32'(m_st != 0));
            chk("m_alu_a", alu_a, m_a);
            chk("m_alu_b", alu_b, m_b);
            chk("m_alu_op", 32'(alu_op), 32'(m_op));
            chk("m_rsp_data", rsp_data, m_d);
            chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
        end
    end

    // One cycle, from just after one rising edge to just after the next; a granted requester drops its request.
    task automatic step();
        logic [3:0] g;
        @(negedge clk);
        g = req_ready;
        @(posedge clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~g;
    endtask

    task automatic wait_rsp(input string nm, input logic [1:0] eid, input logic [31:0] ed);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        if (!rsp_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
        else begin
            chk({nm, "_id"}, 32'(rsp_id), 32'(eid));
            chk({nm, "_data"}, rsp_data, ed);
        end
        step();
    endtask

    logic [1:0]  rr_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] rr_d [5]  = '{32'hFFF0_FFF0, 32'h00F0_00F0, 32'h00E1_00E0, 32'h0F0F_0F10, 32'hFFF0_FFF0};

    initial begin
        // Reset held with everyone requesting
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = 4'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Single ADD from requester 0
        ta[0] = 32'h5; tbv[0] = 32'h7; top[0] = 5'd2;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        chk("add_ready_c0", 32'(req_ready), 32'h1);
        step();
        chk("add_busy_c1", 32'(busy), 32'd1);
        chk("add_valid_c1", 32'(rsp_valid), 32'd0);
        step();
        chk("add_valid_c2", 32'(rsp_valid), 32'd1);
        chk("add_data_c2", rsp_data, 32'h0000_000C);
        chk("add_id_c2", 32'(rsp_id), 32'd0);
        step();
        chk("add_valid_c3", 32'(rsp_valid), 32'd0);
        chk("add_busy_c3", 32'(busy), 32'd0);
        // Wrapping ADD from requester 2
        ta[2] = 32'hFFFF_FFFF; tbv[2] = 32'h1; top[2] = 5'd2;
        req_valid = 4'b0100;
        wait_rsp("wrap", 2'd2, 32'h0);
        // Fresh reset so rotation starts at requester 0
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        auto_drop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ta[i] = 32'hF0F0_F0F0; tbv[i] = 32'h0FF0_0FF0; top[i] = 5'(i);
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) wait_rsp($sformatf("rr%0d", i), rr_id[i], rr_d[i]);
        req_valid = 4'b0;
        auto_drop = 1'b1;
        // Backpressure: req0 result stalls while req1 waits
        ta[0] = 32'h5; tbv[0] = 32'h7; top[0] = 5'd2;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0010;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, 32'h0000_000C);
            chk("bp_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        #1;
        chk("bp_grant_r1", 32'(req_ready), 32'h2);
        wait_rsp("bp_r1", 2'd1, 32'h00F0_00F0);
        // Asynchronous reset while in EXEC
        req_valid = 4'b0100;
        step();
        chk("ar_busy_pre", 32'(busy), 32'd1);
        #2;
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ar_alu_a", alu_a, 32'd0);
        chk("ar_alu_op", 32'(alu_op), 32'd0);
        chk("ar_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ar_ptr0", 32'(req_ready), 32'h1);
        req_valid = 4'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ar_no_rsp", 32'(rsp_valid), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
